// File: rtl/t_ff.sv
// Toggle flip-flop with a synchronous active-low reset.
// q is the only state bit. qb is its combinational complement.
module t_ff #(
  parameter logic RESET_VAL = 1'b0
) (
  output logic q,
  output logic qb,
  input  logic t,
  input  logic clk,
  input  logic reset
);

  logic q_r;
  logic q_next_s;

  // Next-state select: invert the current state when toggle is enabled, otherwise hold
  always_comb begin
    q_next_s = q_r;
    if (t) begin
      q_next_s = ~q_r;
    end else begin
      q_next_s = q_r;
    end
  end

  // State register: reset is sampled only at the clock edge and takes priority over toggle
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q  = q_r;
  assign qb = ~q_r;

endmodule

// File: tb/tb_t_ff.sv
// Directed bench for t_ff.
// The bench drives two instances at once: one uses RESET_VAL=0 and the other uses RESET_VAL=1.
// Expected states come from a small reference model.
// Each expected state is queued when its stimulus is applied, and is popped and compared after the clock edge.
module tb_t_ff;

  logic clk;
  logic t;
  logic reset;
  logic q0, qb0, q1, qb1;

  typedef struct {
    logic  q0;
    logic  q1;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  logic m0, m1;

  t_ff #(.RESET_VAL(1'b0)) dut0 (.q(q0), .qb(qb0), .t(t), .clk(clk), .reset(reset));
  t_ff #(.RESET_VAL(1'b1)) dut1 (.q(q1), .qb(qb1), .t(t), .clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic cmp(input logic obs, input logic exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Compare both instances against model values without touching the queue.
  task automatic cmp_now(input logic e0, input logic e1, input string tag);
    cmp(q0,  e0,  {tag, " q0"});
    cmp(qb0, ~e0, {tag, " qb0"});
    cmp(q1,  e1,  {tag, " q1"});
    cmp(qb1, ~e1, {tag, " qb1"});
  endtask

  task automatic pop_check();
    exp_t e;
    vectors++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d expected=>0", sb.size());
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cmp_now(e.q0, e.q1, e.tag);
    end
  endtask

  // Apply one input pair at the falling edge.
  // Check that nothing changes before the rising edge, then check the result after it.
  task automatic step(input logic tv, input logic rv, input string tag, input bit pre_chk);
    @(negedge clk);
    t     = tv;
    reset = rv;
    #2;
    if (pre_chk) cmp_now(m0, m1, {tag, " pre-edge"});
    if (!rv) begin
      m0 = 1'b0;
      m1 = 1'b1;
    end else if (tv) begin
      m0 = ~m0;
      m1 = ~m1;
    end
    sb.push_back('{q0: m0, q1: m1, tag: tag});
    @(posedge clk);
    #1;
    pop_check();
  endtask

  // Pulse reset low, or t high, entirely between two rising edges.
  // The state must not change.
  task automatic glitch(input bit on_reset, input string tag);
    @(negedge clk);
    t     = 1'b0;
    reset = 1'b1;
    #2;
    if (on_reset) reset = 1'b0; else t = 1'b1;
    #3;
    cmp_now(m0, m1, {tag, " during"});
    if (on_reset) reset = 1'b1; else t = 1'b0;
    sb.push_back('{q0: m0, q1: m1, tag: tag});
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    t     = 1'b0;
    reset = 1'b1;
    m0    = 1'b0;
    m1    = 1'b1;

    // Reset with t=1: reset wins.
    step(1'b1, 1'b0, "reset_t1", 1'b0);
    // Hold for three edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "hold", 1'b1);
    // Toggle for four edges: q0 goes 1,0,1,0.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "toggle", 1'b1);
    // Alternate t=1 then t=0, twice: q0 goes 1,1,0,0.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, "alt_t1", 1'b1);
      step(1'b0, 1'b1, "alt_t0", 1'b1);
    end
    // Bring q0 to 1, then glitch reset and t between edges.
    step(1'b1, 1'b1, "to_one", 1'b1);
    glitch(1'b1, "reset_glitch");
    glitch(1'b0, "t_glitch");
    // Hold reset low across an edge with t=0.
    step(1'b0, 1'b0, "reset_held", 1'b1);
    // Releasing reset alone changes nothing; the next t=1 edge toggles.
    step(1'b0, 1'b1, "release", 1'b1);
    step(1'b1, 1'b1, "first_toggle", 1'b1);
    step(1'b1, 1'b1, "second_toggle", 1'b1);

    vectors++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
